// File: rtl/rk_mem_pkg.sv
// rk_mem_pkg: shared state encoding and constants for the SDRAM arbiter
package rk_mem_pkg;
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_VID = 2'd1,
        ST_BUSY_CPU = 2'd2,
        ST_DONE     = 2'd3
    } state_t;
    localparam logic [7:0] RD_ABORT_DATA = 8'hFF;
    localparam int DEF_ADDR_W = 18;
endpackage

// File: rtl/rk_sdram_arbiter_if.sv
// rk_sdram_arbiter_if: requester and SDRAM controller signals around the arbiter
interface rk_sdram_arbiter_if #(
    parameter int ADDR_W = rk_mem_pkg::DEF_ADDR_W
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_ack;
    logic [7:0]        vid_rdata;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_ack;
    logic [7:0]        cpu_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    modport master (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
        output vid_ack, vid_rdata, cpu_ack, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
        input  vid_ack, vid_rdata, cpu_ack, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/rk_arb_prio.sv
// rk_arb_prio: video-first grant decision bounded by a CPU anti-starvation counter
module rk_arb_prio #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk50mhz,
    input  logic reset_n,
    input  logic i_en,
    input  logic i_vid_req,
    input  logic i_cpu_req,
    output logic o_grant_vid,
    output logic o_grant_cpu
);
    logic [3:0] r_starve;
    logic       w_starved;
    assign w_starved   = r_starve == 4'(STARVE_MAX);
    assign o_grant_cpu = i_en && i_cpu_req && (!i_vid_req || w_starved);
    assign o_grant_vid = i_en && i_vid_req && !o_grant_cpu;
    // Count video wins over a waiting CPU; a CPU grant or a CPU-idle decision cycle restarts it
    always_ff @(posedge clk50mhz) begin
        if (!reset_n)
            r_starve <= '0;
        else if (i_en && (o_grant_cpu || !i_cpu_req))
            r_starve <= '0;
        else if (o_grant_vid)
            r_starve <= r_starve + 4'd1;
    end
endmodule

// File: rtl/rk_sdram_arbiter.sv
// rk_sdram_arbiter: registered CPU/video arbiter in front of the SDRAM controller
module rk_sdram_arbiter
    import rk_mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 63
) (
    input  logic               clk50mhz,
    input  logic               reset_n,
    rk_sdram_arbiter_if.master bus,
    output logic               timeout_err,
    output logic               busy
);
    state_t            r_state;
    logic [7:0]        r_tmo;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic              r_vid_ack;
    logic              r_cpu_ack;
    logic [7:0]        r_vid_rdata;
    logic [7:0]        r_cpu_rdata;
    logic              r_timeout_err;
    logic              w_grant_vid;
    logic              w_grant_cpu;
    logic              w_finish;
    logic [7:0]        w_rdata;

    rk_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
        .clk50mhz    (clk50mhz),
        .reset_n     (reset_n),
        .i_en        (r_state == ST_IDLE),
        .i_vid_req   (bus.vid_req),
        .i_cpu_req   (bus.cpu_req),
        .o_grant_vid (w_grant_vid),
        .o_grant_cpu (w_grant_cpu)
    );

    // mem_ack beats a simultaneous timeout, so real data always wins the race
    assign w_finish = bus.mem_ack || r_tmo == 8'(TIMEOUT_CYC - 1);
    assign w_rdata  = bus.mem_ack ? bus.mem_rdata : RD_ABORT_DATA;

    // Grant, hold the latched access through BUSY, then a one-cycle DONE before re-arbitrating
    always_ff @(posedge clk50mhz) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_tmo         <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_vid_ack     <= 1'b0;
            r_cpu_ack     <= 1'b0;
            r_vid_rdata   <= '0;
            r_cpu_rdata   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_vid_ack <= 1'b0;
            r_cpu_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tmo <= '0;
                    if (w_grant_vid || w_grant_cpu) begin
                        r_state     <= w_grant_vid ? ST_BUSY_VID : ST_BUSY_CPU;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_grant_cpu && bus.cpu_we;
                        r_mem_addr  <= w_grant_vid ? bus.vid_addr : bus.cpu_addr;
                        r_mem_wdata <= w_grant_vid ? 8'h00 : bus.cpu_wdata;
                    end
                end
                ST_BUSY_VID, ST_BUSY_CPU: begin
                    if (w_finish) begin
                        r_state   <= ST_DONE;
                        r_mem_req <= 1'b0;
                        if (!bus.mem_ack)
                            r_timeout_err <= 1'b1;
                        if (r_state == ST_BUSY_VID) begin
                            r_vid_ack   <= 1'b1;
                            r_vid_rdata <= w_rdata;
                        end else begin
                            r_cpu_ack   <= 1'b1;
                            r_cpu_rdata <= w_rdata;
                        end
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.vid_ack   = r_vid_ack;
    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.vid_rdata = r_vid_rdata;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign timeout_err   = r_timeout_err;
    assign busy          = r_state != ST_IDLE;
endmodule

// File: tb/tb_rk_sdram_arbiter.sv
// tb_rk_sdram_arbiter: directed and randomized checks of rk_sdram_arbiter against a grant/data model
module tb_rk_sdram_arbiter;
    localparam int AW = 18;
    localparam int SM = 4;
    localparam int TO = 63;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       timeout_err;
    logic       busy;
    int         n_assert = 0;
    int         n_fail = 0;
    int         run = 0;
    logic [7:0] last_vid = 8'h00;
    logic [7:0] last_cpu = 8'h00;
    bit         cpu_known = 1'b1;
    int         cnt;

    rk_sdram_arbiter_if #(.ADDR_W(AW)) bus ();

    rk_sdram_arbiter #(.ADDR_W(AW), .STARVE_MAX(SM), .TIMEOUT_CYC(TO)) dut (
        .clk50mhz    (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Grant model: the CPU is served once video has won SM times in a row over a waiting CPU
    function automatic bit predict(input bit vr, input bit cr);
        bit v;
        v   = vr && (!cr || run < SM);
        run = (v && cr) ? run + 1 : 0;
        return v;
    endfunction

    // Called at the negedge of an IDLE cycle with requests already driven
    task automatic txn(input bit exp_vid, input int lat, input bit drop, input logic [7:0] rd);
        logic [AW-1:0] ea;
        logic          ew;
        logic [7:0]    ewd;
        ea  = exp_vid ? bus.vid_addr : bus.cpu_addr;
        ew  = !exp_vid && bus.cpu_we;
        ewd = exp_vid ? 8'h00 : bus.cpu_wdata;
        @(negedge clk);
        chk("mem_req_rise", 32'(bus.mem_req), 32'd1);
        chk("mem_addr", 32'(bus.mem_addr), 32'(ea));
        chk("mem_we", 32'(bus.mem_we), 32'(ew));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(ewd));
        for (int i = 1; i < lat; i++) begin
            bus.vid_addr = AW'($urandom);
            bus.cpu_addr = AW'($urandom);
            @(negedge clk);
            chk("mem_hold", 32'({bus.mem_req, bus.mem_addr}), 32'({1'b1, ea}));
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'($urandom);
        chk("mem_req_drop", 32'(bus.mem_req), 32'd0);
        chk("vid_ack", 32'(bus.vid_ack), 32'(exp_vid));
        chk("cpu_ack", 32'(bus.cpu_ack), 32'(!exp_vid));
        chk("busy_done", 32'(busy), 32'd1);
        if (exp_vid) begin
            chk("vid_rdata", 32'(bus.vid_rdata), 32'(rd));
            if (cpu_known) chk("cpu_rdata_hold", 32'(bus.cpu_rdata), 32'(last_cpu));
            last_vid = rd;
        end else begin
            chk("vid_rdata_hold", 32'(bus.vid_rdata), 32'(last_vid));
            if (!ew) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(rd));
            last_cpu  = rd;
            cpu_known = !ew;
        end
        if (drop) begin
            if (exp_vid) bus.vid_req = 1'b0;
            else bus.cpu_req = 1'b0;
        end
        @(negedge clk);
        chk("ack_pulse", 32'({bus.vid_ack, bus.cpu_ack}), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("no_regrant", 32'(bus.mem_req), 32'd0);
    endtask

    initial begin
        bus.vid_req   = 1'b1;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.vid_addr  = 18'h2A5A5;
        bus.cpu_addr  = 18'h01234;
        bus.cpu_wdata = 8'h00;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        // Reset with both requests asserted
        repeat (3) @(negedge clk);
        chk("rst_ctl", 32'({bus.mem_req, bus.mem_we, bus.vid_ack, bus.cpu_ack, timeout_err, busy}), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_rdata", 32'({bus.vid_rdata, bus.cpu_rdata}), 32'd0);
        reset_n = 1'b1;
        run     = 0;
        txn(predict(1'b1, 1'b1), 3, 1'b1, 8'h3C);
        txn(predict(1'b0, 1'b1), 2, 1'b1, 8'h5A);
        // CPU write alone
        bus.cpu_addr  = 18'h01234;
        bus.cpu_wdata = 8'hA5;
        bus.cpu_we    = 1'b1;
        bus.cpu_req   = 1'b1;
        txn(predict(1'b0, 1'b1), 2, 1'b1, 8'h00);
        bus.cpu_we = 1'b0;
        // Starvation bound with both requests held continuously: V,V,V,V,C twice
        bus.vid_req = 1'b1;
        bus.cpu_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            void'(predict(1'b1, 1'b1));
            txn((i % 5) != 4, 3, 1'b0, 8'($urandom));
        end
        bus.vid_req = 1'b0;
        bus.cpu_req = 1'b0;
        run         = 0;
        // Spurious mem_ack while idle
        @(negedge clk);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'h77;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("spur_ack", 32'({bus.vid_ack, bus.cpu_ack, bus.mem_req, busy}), 32'd0);
        @(negedge clk);
        chk("spur_ack2", 32'({bus.vid_ack, bus.cpu_ack}), 32'd0);
        chk("spur_vid_rdata", 32'(bus.vid_rdata), 32'(last_vid));
        // mem_ack on the last BUSY cycle before timeout
        bus.cpu_req = 1'b1;
        txn(predict(1'b0, 1'b1), TO, 1'b1, 8'h96);
        chk("edge_no_tmo", 32'(timeout_err), 32'd0);
        // Timeout on a CPU read that never gets mem_ack
        bus.cpu_req = 1'b1;
        void'(predict(1'b0, 1'b1));
        @(negedge clk);
        cnt = 0;
        while (bus.mem_req && cnt < 80) begin
            cnt++;
            @(negedge clk);
        end
        chk("tmo_len", 32'(cnt), 32'(TO));
        chk("tmo_ack", 32'({bus.cpu_ack, bus.vid_ack}), 32'b10);
        chk("tmo_rdata", 32'(bus.cpu_rdata), 32'hFF);
        chk("tmo_err", 32'(timeout_err), 32'd1);
        last_cpu    = 8'hFF;
        cpu_known   = 1'b1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        chk("tmo_ack_pulse", 32'(bus.cpu_ack), 32'd0);
        bus.vid_req = 1'b1;
        txn(predict(1'b1, 1'b0), 2, 1'b1, 8'hC3);
        chk("tmo_sticky", 32'(timeout_err), 32'd1);
        // Randomized mix; the losing requester keeps its request
        for (int k = 0; k < 40; k++) begin
            bit vr;
            bit cr;
            vr = bus.vid_req || ($urandom_range(0, 1) == 1);
            cr = bus.cpu_req || ($urandom_range(0, 1) == 1);
            if (!vr && !cr) vr = 1'b1;
            if (!bus.cpu_req && cr) begin
                bus.cpu_we    = ($urandom_range(0, 1) == 1);
                bus.cpu_wdata = 8'($urandom);
            end
            bus.vid_req = vr;
            bus.cpu_req = cr;
            txn(predict(vr, cr), int'($urandom_range(1, 6)), 1'b1, 8'($urandom));
        end
        // Reset in the middle of a CPU access, video pending at release
        bus.vid_req = 1'b0;
        bus.cpu_req = 1'b1;
        bus.cpu_we  = 1'b0;
        void'(predict(1'b0, 1'b1));
        @(negedge clk);
        chk("mid_busy", 32'(bus.mem_req), 32'd1);
        bus.vid_req = 1'b1;
        reset_n     = 1'b0;
        @(negedge clk);
        chk("mid_rst", 32'({bus.mem_req, bus.cpu_ack, bus.vid_ack, busy, timeout_err}), 32'd0);
        reset_n   = 1'b1;
        run       = 0;
        last_vid  = 8'h00;
        last_cpu  = 8'h00;
        cpu_known = 1'b1;
        txn(predict(1'b1, 1'b1), 2, 1'b1, 8'($urandom));
        txn(predict(1'b0, 1'b1), 2, 1'b1, 8'($urandom));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/rk_sdram_arbiter.md
Name: rk_sdram_arbiter

Overview:
Shares the single SDRAM controller port between the CPU and the video DMA channel (the 580VT57 channel 2 fetch path).
- Registered request/ack arbitration replaces the combinational vid_rd mux.
- Video has priority, bounded by a CPU anti-starvation counter.
- Each transaction is supervised by a timeout, so a hung SDRAM access cannot lock the bus.
- Sits between the CPU/DMA address logic and SDRAM_Controller in the top level, clocked by clk50mhz.

Parameters:
ADDR_W, 18, SDRAM byte address width (iaddr width of SDRAM_Controller)
STARVE_MAX, 4, max consecutive video grants while cpu_req is pending; range 1..15
TIMEOUT_CYC, 63, cycles in BUSY without mem_ack before abort; range 2..255

Ports:
clk50mhz  in  1  system clock
reset_n  in  1  synchronous active-low reset
vid_req  in  1  video read request; level, held until vid_ack
vid_addr  in  ADDR_W  video read address
vid_ack  out  1  1-cycle pulse; vid_rdata valid in the same cycle
vid_rdata  out  8  video read data
cpu_req  in  1  CPU request; level, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  8  CPU write data
cpu_ack  out  1  1-cycle pulse; cpu_rdata valid in the same cycle
cpu_rdata  out  8  CPU read data
mem_req  out  1  request to SDRAM controller; held high until mem_ack
mem_we  out  1  write strobe to controller, valid while mem_req
mem_addr  out  ADDR_W  controller address
mem_wdata  out  8  controller write data
mem_ack  in  1  controller completion pulse; mem_rdata valid in that cycle
mem_rdata  in  8  controller read data
timeout_err  out  1  sticky flag: a transaction was aborted; cleared only by reset
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: synchronous, sampled on the clk50mhz edge while reset_n = 0.
  - All outputs go to 0; state goes to IDLE; starve counter and timeout counter go to 0.
  - Reset during an in-flight access: mem_req drops on that same edge. No ack is issued to either requester.
- States: IDLE, BUSY_VID, BUSY_CPU, DONE.
- IDLE, grant rules:
  - vid_req only: grant video.
  - cpu_req only: grant CPU.
  - Both requests, starve < STARVE_MAX: grant video and increment starve.
  - Both requests, starve == STARVE_MAX: grant CPU.
- Starve counter:
  - Cleared on every CPU grant.
  - Cleared in any IDLE cycle where cpu_req = 0.
  - Saturates at STARVE_MAX.
- On grant:
  - mem_addr, mem_we and mem_wdata are latched from the winner (video: mem_we = 0, mem_wdata = 0).
  - mem_req = 1 from the next cycle. Grant-to-mem_req latency is exactly 1 cycle.
  - Latched values stay stable for the whole BUSY state; later requester changes are ignored.
- BUSY_x, mem_ack = 1:
  - Capture mem_rdata into x_rdata (CPU writes capture it too; the value is don't-care).
  - Pulse x_ack for exactly 1 cycle, on the cycle after mem_ack.
  - Drop mem_req on the same edge; go to DONE.
- BUSY_x timeout: timeout counter increments each BUSY cycle.
  - When it reaches TIMEOUT_CYC: drop mem_req, pulse x_ack with x_rdata = 8'hFF, set timeout_err, go to DONE.
  - mem_ack and timeout in the same cycle: mem_ack wins; data is captured normally; timeout_err is not set.
- DONE: exactly 1 cycle, no grant evaluated, then IDLE.
  - The requester must deassert req in the cycle after its ack; DONE guarantees a stale req is never re-granted.
  - Back-to-back throughput: grant → mem_req → ack → DONE → IDLE gives a minimum 4-cycle spacing plus controller latency.
- mem_ack in IDLE or DONE: ignored; no ack is generated.
- x_rdata holds its value until the next capture for the same requester.
- Widths: starve counter 4 bits; timeout counter 8 bits; no wrap, because both compare before increment.

Decomposition:
- Shared package rk_mem_pkg:
  - state encoding (2-bit constants ST_IDLE, ST_BUSY_VID, ST_BUSY_CPU, ST_DONE);
  - constant RD_ABORT_DATA = 8'hFF;
  - default ADDR_W = 18.
- One sub-module is natural: rk_arb_prio.
  - Combinational grant decision with registered starve counter.
  - Inputs: vid_req, cpu_req, an enable from the FSM.
  - Outputs: grant_vid, grant_cpu.
- The FSM, latches and timeout stay in the top module.

Test Plan:
1. Reset: hold reset_n = 0 with vid_req = cpu_req = 1 → all outputs 0. Release reset, mem_ack after 3 cycles → mem_req rises 1 cycle after release with mem_addr = vid_addr. vid_ack pulses 1 cycle after mem_ack; cpu_ack stays 0.
2. CPU write alone: cpu_addr = 18'h01234, cpu_wdata = 8'hA5, cpu_we = 1 → mem_we = 1, mem_addr = 18'h01234, mem_wdata = 8'hA5 while mem_req. cpu_ack is a single-cycle pulse; busy drops 2 cycles after mem_ack.
3. Starvation bound: vid_req and cpu_req held continuously, STARVE_MAX = 4, mem_ack 2 cycles after each mem_req → grant order is V,V,V,V,C,V,V,V,V,C. The CPU grant always follows exactly 4 video grants.
4. Timeout: CPU read, mem_ack never asserted, TIMEOUT_CYC = 63 → mem_req high for exactly 63 cycles. Then cpu_ack = 1 with cpu_rdata = 8'hFF, and timeout_err = 1 (sticky). A subsequent normal video read completes correctly.
5. Edge collisions:
   - mem_ack on the 63rd BUSY cycle → normal data returned, timeout_err stays 0.
   - Spurious mem_ack in IDLE → no ack pulses.
   - Requester keeps req high through DONE → no re-grant until IDLE.
6. Reset mid-access: reset_n = 0 while BUSY_CPU → mem_req = 0 on the next edge, no cpu_ack. After release, the pending video request is granted first.
